parity_even_odd: RTL and testbench

Registered even/odd parity generator for the `p_e_o` block: samples a WIDTH-bit data word and produces both the even-parity bit and the odd-parity bit one clock later. It sits on the datapath ahead of any serializer or storage stage that appends a parity bit. An optional receive-side checker can be compiled in to flag parity mismatches.

---
 rtl/parity_even_odd.sv | 95 +++++++++
 tb/tb_parity_even_odd.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/parity_even_odd.sv
// parity_even_odd: registered even/odd parity generator for the p_e_o block.
// A WIDTH-bit word sampled with in_valid yields oe (even parity) and od (odd
// parity) one clock later, with out_valid marking the cycle of the new result.
// Optional receive-side checker: define PEO_CHECK_EN to add chk_in/err/err_cnt.
//
// Handshake: in_valid/out_valid are strict valid-only qualifiers. There is no
// ready; every edge with in_valid=1 (and rst=0) accepts a word, and out_valid
// is high for exactly the one cycle after that edge.

module parity_even_odd #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             in_valid,
    output logic             oe,
    output logic             od,
    output logic             out_valid
`ifdef PEO_CHECK_EN
    ,
    input  logic             chk_in,
    output logic             err,
    output logic [7:0]       err_cnt
`endif
);

    // XOR of every bit of the incoming word.
    logic par;
    assign par = ^i;

    logic oe_d, oe_q;
    logic od_d, od_q;
    logic out_valid_d, out_valid_q;

    // Next-state: load both parity bits on a valid word, otherwise hold them.
    always_comb begin
        oe_d        = oe_q;
        od_d        = od_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            oe_d = par;
            od_d = ~par;
        end
    end

    // Generator registers; reset wins over a word presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe_q        <= 1'b0;
            od_q        <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            oe_q        <= oe_d;
            od_q        <= od_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign oe        = oe_q;
    assign od        = od_q;
    assign out_valid = out_valid_q;

`ifdef PEO_CHECK_EN
    logic       err_d, err_q;
    logic [7:0] err_cnt_d, err_cnt_q;

    // Checker next-state: even-parity check of {i, chk_in}; counter saturates at 255.
    always_comb begin
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        if (in_valid) begin
            err_d = par ^ chk_in;
        end
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Checker registers; the count clears only on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_even_odd.sv
// Bench for parity_even_odd: directed vectors, a spec-level model with an
// expected-result queue checked every cycle, and literal expectations.
// Build with or without PEO_CHECK_EN.

module tb_parity_even_odd;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic [3:0] i = 4'd0;
    logic       in_valid = 1'b0;
    logic       oe, od, out_valid;
    logic [7:0] i8 = 8'd0;
    logic       v8 = 1'b0;
    logic       oe8, od8, ov8;

`ifdef PEO_CHECK_EN
    logic       chk_in = 1'b0;
    logic       err;
    logic [7:0] err_cnt;
    logic       err8;
    logic [7:0] err_cnt8;
`endif

    parity_even_odd #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i         (i),
        .in_valid  (in_valid),
        .oe        (oe),
        .od        (od),
        .out_valid (out_valid)
`ifdef PEO_CHECK_EN
        ,
        .chk_in    (chk_in),
        .err       (err),
        .err_cnt   (err_cnt)
`endif
    );

    parity_even_odd #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .i         (i8),
        .in_valid  (v8),
        .oe        (oe8),
        .od        (od8),
        .out_valid (ov8)
`ifdef PEO_CHECK_EN
        ,
        .chk_in    (1'b0),
        .err       (err8),
        .err_cnt   (err_cnt8)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_on  = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model + scoreboard ----------------
    // Parity from the bit count; results queued on each accepted word and
    // consumed when the DUT presents out_valid.
    logic [0:0] exp_q[$];
    logic       m_valid, m_oe;
    logic       m_err;
    int         m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_oe    = 1'b0;
            m_err   = 1'b0;
            m_cnt   = 0;
        end else if (in_valid) begin
            m_oe    = ($countones(i) % 2) == 1;
            m_valid = 1'b1;
            exp_q.push_back(m_oe);
`ifdef PEO_CHECK_EN
            m_err = m_oe != chk_in;
            if (m_err && m_cnt < 255) m_cnt++;
`endif
        end else begin
            m_valid = 1'b0;
            m_err   = 1'b0;
        end
    end

    // Compare process: every falling edge once the model has been reset.
    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_out_valid", {7'd0, out_valid}, {7'd0, m_valid});
            check("mon_oe", {7'd0, oe}, {7'd0, m_oe});
            check("mon_od_inv", {7'd0, od}, {7'd0, ~oe});
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("mon_queue_empty", 8'd1, 8'd0);
                end else begin
                    check("mon_q_oe", {7'd0, oe}, {7'd0, exp_q.pop_front()});
                end
            end
`ifdef PEO_CHECK_EN
            check("mon_err", {7'd0, err}, {7'd0, m_err});
            check("mon_err_cnt", err_cnt, 8'(m_cnt));
`endif
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic v, input logic [3:0] d, input logic c);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        i        = d;
`ifdef PEO_CHECK_EN
        chk_in   = c;
`else
        if (c) begin end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic [7:0] d);
        @(negedge clk);
        i8 = d;
        v8 = 1'b1;
        @(posedge clk);
        #1;
        v8 = 1'b0;
    endtask

    // Parity of words 0..13, bit k = parity of k.
    logic [13:0] sweep_par;

    initial begin
        sweep_par = 14'b10_1001_1001_0110;

        // Reset held 2 cycles with a valid word present.
        step(1'b1, 1'b1, 4'b1011, 1'b0);
        mon_on = 1'b1;
        step(1'b1, 1'b1, 4'b1011, 1'b0);
        check("rst_oe", {7'd0, oe}, 8'd0);
        check("rst_od", {7'd0, od}, 8'd1);
        check("rst_valid", {7'd0, out_valid}, 8'd0);

        // Sweep 0000..1101 back to back.
        for (int k = 0; k < 14; k++) begin
            step(1'b0, 1'b1, 4'(k), 1'b0);
            check("sweep_oe", {7'd0, oe}, {7'd0, sweep_par[k]});
            check("sweep_od", {7'd0, od}, {7'd0, ~sweep_par[k]});
            check("sweep_valid", {7'd0, out_valid}, 8'd1);
        end

        // Hold.
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        check("hold_load_oe", {7'd0, oe}, 8'd1);
        step(1'b0, 1'b0, 4'b0011, 1'b0);
        check("hold_oe", {7'd0, oe}, 8'd1);
        check("hold_od", {7'd0, od}, 8'd0);
        check("hold_valid", {7'd0, out_valid}, 8'd0);

        // Reset mid-stream.
        step(1'b0, 1'b1, 4'b0111, 1'b0);
        check("mid_oe", {7'd0, oe}, 8'd1);
        step(1'b1, 1'b1, 4'b0111, 1'b0);
        check("mid_rst_oe", {7'd0, oe}, 8'd0);
        check("mid_rst_od", {7'd0, od}, 8'd1);
        check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
        step(1'b0, 1'b0, 4'b0111, 1'b0);
        check("post_rst_valid", {7'd0, out_valid}, 8'd0);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        check("post_rst_first_valid", {7'd0, out_valid}, 8'd1);
        check("post_rst_first_oe", {7'd0, oe}, 8'd1);

`ifdef PEO_CHECK_EN
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 4'b0001, 1'b1);
        check("chk_ok_err", {7'd0, err}, 8'd0);
        check("chk_ok_cnt", err_cnt, 8'd0);
        step(1'b0, 1'b1, 4'b0001, 1'b0);
        check("chk_bad_err", {7'd0, err}, 8'd1);
        check("chk_bad_cnt", err_cnt, 8'd1);
        for (int k = 0; k < 300; k++) step(1'b0, 1'b1, 4'b0011, 1'b1);
        check("chk_sat_cnt", err_cnt, 8'd255);
        step(1'b0, 1'b0, 4'b0011, 1'b1);
        check("chk_idle_err", {7'd0, err}, 8'd0);
        check("chk_idle_cnt", err_cnt, 8'd255);
`endif

        // Random valid/idle traffic for the monitor.
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end

        // WIDTH = 8 instance.
        step8(8'hFF);
        check("w8_ff_oe", {7'd0, oe8}, 8'd0);
        check("w8_ff_od", {7'd0, od8}, 8'd1);
        check("w8_ff_valid", {7'd0, ov8}, 8'd1);
        step8(8'h80);
        check("w8_80_oe", {7'd0, oe8}, 8'd1);
        check("w8_80_od", {7'd0, od8}, 8'd0);

        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
